regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port arbiter and pending-write scoreboard for the 32 x 32-bit register file (`regfile`). It shares the regfile's single write port (`we`/`rd`/`wd`) between NREQ writeback sources (e.g. ALU, load unit, multi-cycle mul/div) using round-robin arbitration with a valid/ready handshake. It also tracks which architectural registers have a write in flight, so issue logic can stall on RAW hazards. It sits between the pipeline writeback sources and `regfile`.

## Interface
- NREQ, 3: number of writeback requesters (2..8)
- XLEN, 32: data width
- AW, 5: register address width (32 registers, x0 hard-wired zero)

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  requester i has a write pending
- req_rd  input  NREQ x AW  destination register per requester
- req_wd  input  NREQ x XLEN  write data per requester
- req_ready  output  NREQ  one-hot grant; handshake completes when valid & ready
- rf_we  output  1  to regfile `we`, registered
- rf_rd  output  AW  to regfile `rd`, registered
- rf_wd  output  XLEN  to regfile `wd`, registered
- issue_valid  input  1  an instruction writing issue_rd is issuing this cycle
- issue_rd  input  AW  destination of the issuing instruction
- rs1, rs2  input  AW  source registers of the instruction at issue
- rs1_busy, rs2_busy  output  1  source has a pending write (combinational)

## Operation
- Arbitration: round-robin. Pointer `last` holds the index of the last granted requester. Search order is last+1, last+2, ... wrapping modulo NREQ. The first requester with req_valid=1 gets req_ready=1. At most one grant per cycle.
- req_ready is combinational from req_valid and `last`. It never depends on req_rd or req_wd.
- Requesters hold valid/rd/wd stable until they see ready. Deasserting valid before ready is legal and simply withdraws the request.
- `last` updates only on a grant. With no valid request, `last` holds.
- On a grant, rf_rd/rf_wd register the winner's rd/wd. rf_we registers 1 unless the winner's rd==0. A write to x0 is consumed (ready asserted) but produces rf_we=0.
- With no grant, rf_we registers 0. rf_rd and rf_wd hold their previous values.
- Scoreboard: `busy[31:0]`, bit 0 always 0.
  - Set on issue_valid with issue_rd != 0.
  - Cleared when a grant for that register occurs, at the same edge that loads rf_we.
- Simultaneous set and clear of the same register: set wins.
- rsN_busy = busy[rsN]. This output is combinational and does not see a same-cycle issue_valid.
- Reset (asynchronous, any time):
  - rf_we=0, rf_rd=0, rf_wd=0.
  - busy all 0.
  - `last`=NREQ-1, so requester 0 has first priority.
  - Any in-flight registered write is dropped.

## Timing
- Grant in cycle N means rf_we/rf_rd/rf_wd are valid during cycle N+1. The regfile commits at the end of N+1.
- Latency from request to regfile write: 1 register stage. Sustained throughput: 1 write per cycle.
- A requester that is valid continuously waits at most NREQ-1 cycles for a grant.
- busy clears at the edge ending cycle N, so rsN_busy is 0 during N+1, the same cycle the regfile write is presented. The issue stage is responsible for forwarding rf_wd or waiting one cycle.
- Outputs are glitch-free registered, except req_ready and rsN_busy.

## Configuration
- Macro: RF_ARB_SCOREBOARD_EN
- Defined: the busy vector and rs1_busy/rs2_busy logic are present as described above.
- Undefined: the busy vector is removed. rs1_busy and rs2_busy are tied to 0. issue_valid and issue_rd are ignored. The arbiter and write path are unchanged.

## Structure
- Package `rf_pkg`:
  - constants XLEN=32, AW=5, NREG=32
  - typedef `reg_addr_t` (logic [AW-1:0])
  - typedef `xword_t` (logic [XLEN-1:0])
- Sub-module `rr_arbiter` (parameter N): inputs req, last; outputs one-hot gnt and gnt_idx. Purely combinational, so it can be reused for other shared resources.
- Top module holds `last`, the output register stage and the scoreboard.

## Test plan
- Reset: hold rst_n=0, then release. Expect rf_we=0, rf_rd=0, rf_wd=0, rs1_busy=0 and rs2_busy=0 for all rs values.
- Single write: req 1 valid, rd=5, wd=42. Expect req_ready[1]=1 in the same cycle, then rf_we=1, rf_rd=5, rf_wd=42 next cycle, and the regfile reads 42 from x5 afterwards.
- Fairness: all 3 requesters valid continuously with distinct rd (5, 10, 15). Expect grant order 0,1,2,0,1,2 and rf_we=1 every cycle.
- x0 write: req 0 valid, rd=0, wd=84. Expect req_ready[0]=1, then rf_we=0 next cycle, and x0 still reads 0.
- Scoreboard:
  - issue_valid with issue_rd=10, then rs1=10: expect rs1_busy=1.
  - A grant for rd=10 clears it: expect rs1_busy=0 the next cycle.
  - Issue rd=10 in the same cycle as a grant for rd=10: expect busy to stay 1.
- Reset mid-operation: assert rst_n=0 while a grant is registered and busy[5]=1. Expect rf_we=0 and busy[5]=0 immediately, and requester 0 granted first after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the writeback path.
package rf_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bundle: one valid/ready handshake with rd/wd per requester.
interface regfile_wr_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) ();

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][AW-1:0]   req_rd;
  logic [NREQ-1:0][XLEN-1:0] req_wd;

  modport master (
    output req_valid,
    output req_rd,
    output req_wd,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_wd,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past `last`, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!found && req[idx[IW-1:0]]) begin
        found               = 1'b1;
        gnt[idx[IW-1:0]]    = 1'b1;
        gnt_idx             = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the regfile write port plus a pending-write scoreboard.
// Define RF_ARB_SCOREBOARD_EN to build the busy vector; otherwise rs1_busy/rs2_busy read 0.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = rf_pkg::XLEN,
  parameter int unsigned AW   = rf_pkg::AW,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  req,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wd,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any_gnt;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_wd;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req     (req.req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req.req_ready = gnt;
  assign any_gnt       = |gnt;
  assign win_rd        = req.req_rd[gnt_idx];
  assign win_wd        = req.req_wd[gnt_idx];

  // Writes to x0 still complete the handshake but never reach the regfile.
  always_comb begin
    last_d  = last_q;
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (any_gnt) begin
      last_d  = gnt_idx;
      rf_we_d = (win_rd != '0);
      rf_rd_d = win_rd;
      rf_wd_d = win_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= IW'(NREQ - 1);
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else begin
      last_q  <= last_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_rd = rf_rd_q;
  assign rf_wd = rf_wd_q;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam int unsigned NR = 1 << AW;

  logic [NR-1:0] busy_q, busy_d;

  // Clear applied before set so a same-edge issue to the granted register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (any_gnt) begin
      busy_d[win_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd, rs1, rs2};
  assign rs1_busy     = 1'b0;
  assign rs2_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: predicted writes are queued at grant, checked a cycle later.
module tb_regfile_wr_arbiter;
  import rf_pkg::*;

  localparam int unsigned N = 3;
`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst_n;
  logic      rf_we;
  reg_addr_t rf_rd;
  xword_t    rf_wd;
  logic      issue_valid;
  reg_addr_t issue_rd, rs1, rs2;
  logic      rs1_busy, rs2_busy;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(N), .XLEN(XLEN), .AW(AW)) rif ();

  regfile_wr_arbiter #(
    .NREQ (N),
    .XLEN (XLEN),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (rif),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wd       (rf_wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

  // Behavioural regfile fed by the DUT write port.
  xword_t mem [NREG];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREG); r++) mem[r] <= '0;
    end else if (rf_we && rf_rd != '0) begin
      mem[rf_rd] <= rf_wd;
    end
  end

  typedef struct packed {
    logic      we;
    reg_addr_t rd;
    xword_t    wd;
  } wr_t;

  wr_t          exp_q [$];
  int           n_total = 0;
  int           n_bad   = 0;
  int           m_last;
  reg_addr_t    m_rd;
  xword_t       m_wd;
  logic [31:0]  m_busy;
  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [N-1:0] rr_model(input logic [N-1:0] v, input int l);
    logic [N-1:0] one;
    int k;
    one = 1;
    for (int i = 1; i <= int'(N); i++) begin
      k = (l + i) % int'(N);
      if (v[k]) return one << k;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_rd   = '0;
    m_wd   = '0;
    m_busy = '0;
    exp_q.delete();
  endtask

  // Called just after a rising edge: predicts this cycle, then checks the registered result.
  task automatic cycle();
    logic [N-1:0] g;
    wr_t          e;
    int           gi;
    @(negedge clk);
    g          = rr_model(rif.req_valid, m_last);
    last_ready = rif.req_ready;
    check("req_ready", {61'b0, rif.req_ready}, {61'b0, g});
    check("rs1_busy", {63'b0, rs1_busy}, {63'b0, SB ? m_busy[rs1] : 1'b0});
    check("rs2_busy", {63'b0, rs2_busy}, {63'b0, SB ? m_busy[rs2] : 1'b0});
    e.we = 1'b0;
    e.rd = m_rd;
    e.wd = m_wd;
    if (g != '0) begin
      gi = 0;
      for (int i = 0; i < int'(N); i++) if (g[i]) gi = i;
      e.rd   = rif.req_rd[gi];
      e.wd   = rif.req_wd[gi];
      e.we   = (e.rd != '0);
      m_last = gi;
      m_busy[e.rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    m_rd = e.rd;
    m_wd = e.wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", {63'b0, rf_we}, {63'b0, e.we});
    check("rf_rd", {59'b0, rf_rd}, {59'b0, e.rd});
    check("rf_wd", {32'b0, rf_wd}, {32'b0, e.wd});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    rif.req_valid = '0;
    rif.req_rd    = '0;
    rif.req_wd    = '0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    rs1           = '0;
    rs2           = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rf_we", {63'b0, rf_we}, 64'd0);
    check("rst_rf_rd", {59'b0, rf_rd}, 64'd0);
    check("rst_rf_wd", {32'b0, rf_wd}, 64'd0);
    for (int r = 0; r < int'(NREG); r++) begin
      rs1 = reg_addr_t'(r);
      rs2 = reg_addr_t'(31 - r);
      #1;
      check("rst_rs1_busy", {63'b0, rs1_busy}, 64'd0);
      check("rst_rs2_busy", {63'b0, rs2_busy}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Fairness from reset: 0,1,2,0,1,2 with a write every cycle.
    rif.req_rd[0] = 5'd5;  rif.req_wd[0] = 32'h1111;
    rif.req_rd[1] = 5'd10; rif.req_wd[1] = 32'h2222;
    rif.req_rd[2] = 5'd15; rif.req_wd[2] = 32'h3333;
    rif.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("fair_gnt", {61'b0, last_ready}, 64'd1 << (k % 3));
      check("fair_we", {63'b0, rf_we}, 64'd1);
    end
    rif.req_valid = '0;
    cycle();
    check("x15_read", {32'b0, mem[15]}, 64'h3333);

    // Single write from requester 1.
    rif.req_valid = 3'b010;
    rif.req_rd[1] = 5'd5;
    rif.req_wd[1] = 32'd42;
    cycle();
    check("single_ready", {61'b0, last_ready}, 64'b010);
    rif.req_valid = '0;
    cycle();
    check("x5_read", {32'b0, mem[5]}, 64'd42);

    // x0 write is consumed without a regfile write.
    rif.req_valid = 3'b001;
    rif.req_rd[0] = 5'd0;
    rif.req_wd[0] = 32'd84;
    cycle();
    check("x0_ready", {61'b0, last_ready}, 64'b001);
    check("x0_we", {63'b0, rf_we}, 64'd0);
    rif.req_valid = '0;
    cycle();

    // Scoreboard set, clear, and set-wins.
    rs1 = 5'd10;
    rs2 = 5'd10;
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    cycle();
    issue_valid = 1'b0;
    check("sb_set", {63'b0, rs1_busy}, {63'b0, SB});
    rif.req_valid = 3'b100;
    rif.req_rd[2] = 5'd10;
    rif.req_wd[2] = 32'd99;
    cycle();
    rif.req_valid = '0;
    check("sb_clear", {63'b0, rs1_busy}, 64'd0);
    issue_valid = 1'b1;
    cycle();
    rif.req_valid = 3'b100;
    cycle();
    check("sb_set_wins", {63'b0, rs2_busy}, {63'b0, SB});
    issue_valid   = 1'b0;
    cycle();
    rif.req_valid = '0;
    check("sb_clear2", {63'b0, rs1_busy}, 64'd0);
    cycle();

    // Asynchronous reset with a registered write and busy[5] pending.
    rs1 = 5'd5;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    cycle();
    issue_valid   = 1'b0;
    rif.req_valid = 3'b010;
    rif.req_rd[1] = 5'd7;
    rif.req_wd[1] = 32'd77;
    cycle();
    check("pre_arst_busy5", {63'b0, rs1_busy}, {63'b0, SB});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", {63'b0, rf_we}, 64'd0);
    check("arst_rd", {59'b0, rf_rd}, 64'd0);
    check("arst_wd", {32'b0, rf_wd}, 64'd0);
    check("arst_busy5", {63'b0, rs1_busy}, 64'd0);
    rif.req_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rif.req_rd[0] = 5'd5;
    rif.req_rd[1] = 5'd10;
    rif.req_rd[2] = 5'd15;
    rif.req_valid = 3'b111;
    cycle();
    check("post_arst_gnt", {61'b0, last_ready}, 64'b001);
    rif.req_valid = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
